// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb: integer register file with a scoreboard
//
// Holds NREGS registers of XLEN bits. Register 0 is hard-wired to zero. Each
// register carries a busy bit that is set when an instruction reserves it as
// its destination (issue port) and cleared when the result comes back (write
// port). The number of outstanding reservations is capped at MAX_PENDING.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous active-high reset
//   rs1_* / rs2_*    two combinational read ports: data and busy flag
//   rd_*             write port (address, enable, data)
//   issue_valid      request to reserve issue_rd as a destination
//   issue_rd         destination to reserve
//   issue_ready      reservation would be accepted this cycle
//   pending_count    number of outstanding reservations
//
// Configuration
//   REGFILE_SB_BYPASS_EN  when defined, a write in flight is forwarded to a
//                         read port addressing the same register in the same
//                         cycle (data = write data, busy = 0). When undefined,
//                         reads see the stored value until the next cycle.
// ----------------------------------------------------------------------------
module regfile_sb #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NREGS       = 32,
    parameter int unsigned MAX_PENDING = 4,
    localparam int unsigned AW         = $clog2(NREGS),
    localparam int unsigned PW         = $clog2(MAX_PENDING + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_address,
    output logic [XLEN-1:0] rs1_read_data,
    output logic            rs1_busy,
    input  logic [AW-1:0]   rs2_address,
    output logic [XLEN-1:0] rs2_read_data,
    output logic            rs2_busy,
    input  logic [AW-1:0]   rd_address,
    input  logic            rd_write_enable,
    input  logic [XLEN-1:0] rd_write_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    output logic [PW-1:0]   pending_count
);

    localparam logic [PW-1:0] MaxPending = PW'(MAX_PENDING);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [PW-1:0]    pending_q;
    logic [PW-1:0]    pending_d;

    // ------------------------------------------------------------------------
    // Write / issue qualification
    // ------------------------------------------------------------------------
    logic wr_en;       // write to a real (non-zero) register
    logic wr_clears;   // that write retires an outstanding reservation
    logic issue_fire;  // reservation actually taken this cycle

    assign wr_en     = rd_write_enable && (rd_address != '0);
    assign wr_clears = wr_en && busy_q[rd_address];

    // Reserving x0 is always "accepted" but has no effect; otherwise the
    // target must be free and there must be room for another reservation.
    // Deliberately independent of issue_valid so the issuer can look ahead.
    always_comb begin
        issue_ready = 1'b1;
        if (issue_rd != '0) begin
            issue_ready = !busy_q[issue_rd] && (pending_q < MaxPending);
        end
    end

    assign issue_fire = issue_valid && issue_ready && (issue_rd != '0);

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        pending_d = pending_q;

        if (wr_en) begin
            regs_d[rd_address] = rd_write_data;
            busy_d[rd_address] = 1'b0;
        end

        // Applied after the write so that a write and a reservation of the
        // same (free) register in one cycle leaves it busy. A busy register
        // cannot be reserved, so the opposite ordering question never arises.
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end

        busy_d[0] = 1'b0;

        // The counter moves only when exactly one side changes it; the
        // issue_ready guard keeps it at or below MaxPending and wr_clears
        // implies at least one reservation, so it cannot underflow.
        case ({issue_fire, wr_clears})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q    <= '{default: '0};
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    // Forwarding is suppressed while reset is asserted so the read ports show
    // the cleared state even if a write strobe is presented during reset.
    logic fwd_en;
`ifdef REGFILE_SB_BYPASS_EN
    assign fwd_en = wr_en && !reset;
`else
    assign fwd_en = 1'b0;
`endif

    always_comb begin
        rs1_read_data = '0;
        rs1_busy      = 1'b0;
        if (rs1_address != '0) begin
            if (fwd_en && (rs1_address == rd_address)) begin
                rs1_read_data = rd_write_data;
                rs1_busy      = 1'b0;
            end else begin
                rs1_read_data = regs_q[rs1_address];
                rs1_busy      = busy_q[rs1_address];
            end
        end
    end

    always_comb begin
        rs2_read_data = '0;
        rs2_busy      = 1'b0;
        if (rs2_address != '0) begin
            if (fwd_en && (rs2_address == rd_address)) begin
                rs2_read_data = rd_write_data;
                rs2_busy      = 1'b0;
            end else begin
                rs2_read_data = regs_q[rs2_address];
                rs2_busy      = busy_q[rs2_address];
            end
        end
    end

    assign pending_count = pending_q;

    // ------------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    // The counter is a cached popcount of the busy vector.
    a_pending_matches_busy: assert property (
        @(posedge clock) disable iff (reset)
        $countones(busy_q) == int'(pending_q)
    );

    a_pending_bounded: assert property (
        @(posedge clock) disable iff (reset)
        pending_q <= MaxPending
    );

    a_x0_never_busy: assert property (
        @(posedge clock) disable iff (reset)
        !busy_q[0]
    );
`endif

endmodule

// File: tb/tb_regfile_sb.sv
`timescale 1ns/1ps
module tb_regfile_sb;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned NREGS       = 32;
    localparam int unsigned MAX_PENDING = 4;
    localparam int unsigned AW          = 5;
    localparam int unsigned PW          = 3;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [AW-1:0]   rs1_address;
    logic [XLEN-1:0] rs1_read_data;
    logic            rs1_busy;
    logic [AW-1:0]   rs2_address;
    logic [XLEN-1:0] rs2_read_data;
    logic            rs2_busy;
    logic [AW-1:0]   rd_address;
    logic            rd_write_enable;
    logic [XLEN-1:0] rd_write_data;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic [PW-1:0]   pending_count;

    regfile_sb #(
        .XLEN       (XLEN),
        .NREGS      (NREGS),
        .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rs1_address    (rs1_address),
        .rs1_read_data  (rs1_read_data),
        .rs1_busy       (rs1_busy),
        .rs2_address    (rs2_address),
        .rs2_read_data  (rs2_read_data),
        .rs2_busy       (rs2_busy),
        .rd_address     (rd_address),
        .rd_write_enable(rd_write_enable),
        .rd_write_data  (rd_write_data),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_ready    (issue_ready),
        .pending_count  (pending_count)
    );

    always #5 clock = ~clock;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: plain arrays, occupancy derived by counting.
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic bit m_fwd(input logic [AW-1:0] a);
        return Bypass && rd_write_enable && (rd_address != 0) && (rd_address == a);
    endfunction

    function automatic logic [XLEN-1:0] m_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (m_fwd(a)) return rd_write_data;
        return m_regs[a];
    endfunction

    function automatic bit m_busy_of(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (m_fwd(a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit m_ready();
        if (issue_rd == 0) return 1'b1;
        return !m_busy[issue_rd] && (m_pending() < MAX_PENDING);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic m_update();
        bit take;
        take = m_ready() && issue_valid && (issue_rd != 0);
        if (rd_write_enable && rd_address != 0) begin
            m_regs[rd_address] = rd_write_data;
            m_busy[rd_address] = 1'b0;
        end
        if (take) m_busy[issue_rd] = 1'b1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " rs1_data"}, 64'(rs1_read_data), 64'(m_data(rs1_address)));
        check({tag, " rs1_busy"}, 64'(rs1_busy), 64'(m_busy_of(rs1_address)));
        check({tag, " rs2_data"}, 64'(rs2_read_data), 64'(m_data(rs2_address)));
        check({tag, " rs2_busy"}, 64'(rs2_busy), 64'(m_busy_of(rs2_address)));
        check({tag, " issue_ready"}, 64'(issue_ready), 64'(m_ready()));
        check({tag, " pending"}, 64'(pending_count), 64'(m_pending()));
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] rd, input logic [XLEN-1:0] wd,
                         input logic iv, input logic [AW-1:0] ird,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        rd_write_enable = we;
        rd_address      = rd;
        rd_write_data   = wd;
        issue_valid     = iv;
        issue_rd        = ird;
        rs1_address     = r1;
        rs2_address     = r2;
    endtask

    // Advance one clock with the model stepping on the same inputs.
    task automatic tick();
        m_update();
        @(posedge clock);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed table: inputs plus expected pre-edge outputs.
    // ------------------------------------------------------------------------
    typedef struct {
        logic            we;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] wd;
        logic            iv;
        logic [AW-1:0]   ird;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [XLEN-1:0] e_d1;
        logic            e_b1;
        logic [XLEN-1:0] e_d2;
        logic            e_b2;
        logic            e_rdy;
        logic [PW-1:0]   e_pend;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          we    rd     wd             iv    ird    rs1    rs2    d1            b1    d2            b2    rdy   pend
        vecs[0]  = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 3'd0};
        vecs[1]  = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0,  5'd1,  5'd2,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 3'd0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd0,  5'd5,  32'h0,        1'b0, 32'h12345678, 1'b0, 1'b1, 3'd0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  5'd3,  5'd5,  32'h0,        1'b1, 32'h12345678, 1'b0, 1'b1, 3'd1};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  5'd4,  5'd3,  32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 3'd2};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd6,  5'd0,  32'h0,        1'b1, 32'h0,        1'b0, 1'b1, 3'd3};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  5'd7,  5'd8,  32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 3'd4};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd3,  5'd4,  32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 3'd4};
        vecs[8]  = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd8,  5'd3,  5'd6,  32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 3'd4};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  5'd4,  5'd8,  32'h44,       1'b0, 32'h0,        1'b0, 1'b1, 3'd3};
        vecs[10] = '{1'b1, 5'd6,  32'h66,       1'b0, 5'd0,  5'd8,  5'd7,  32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 3'd4};
        vecs[11] = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd9,  5'd6,  5'd9,  32'h66,       1'b0, 32'h0,        1'b0, 1'b1, 3'd3};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd3,  5'd9,  32'h33,       1'b0, 32'h0,        1'b1, 1'b0, 3'd3};
        vecs[13] = '{1'b1, 5'd10, 32'hA0,       1'b1, 5'd10, 5'd7,  5'd8,  32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 3'd3};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd11, 5'd10, 5'd9,  32'hA0,       1'b1, 32'h0,        1'b1, 1'b0, 3'd4};
        vecs[15] = '{1'b1, 5'd5,  32'h55,       1'b0, 5'd0,  5'd10, 5'd1,  32'hA0,       1'b1, 32'h0,        1'b0, 1'b1, 3'd4};
        vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'h55,       1'b0, 32'h0,        1'b0, 1'b1, 3'd4};

        // ---- Reset with write/issue strobes present: all ignored ----------
        reset = 1'b1;
        m_reset();
        drive(1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 5'd3, 5'd3);
        #2;
        check("in_reset rs1_data", 64'(rs1_read_data), 64'h0);
        check("in_reset rs1_busy", 64'(rs1_busy), 64'h0);
        check("in_reset rs2_data", 64'(rs2_read_data), 64'h0);
        check("in_reset issue_ready", 64'(issue_ready), 64'h1);
        @(posedge clock);
        #1;
        check("in_reset_edge rs1_data", 64'(rs1_read_data), 64'h0);
        check("in_reset_edge pending", 64'(pending_count), 64'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        reset = 1'b0;

        // ---- Every address on both ports after reset -----------------------
        for (int a = 0; a < NREGS; a++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, AW'(a), AW'(a), AW'(NREGS - 1 - a));
            #1;
            check_model($sformatf("post_reset a%0d", a));
        end
        @(posedge clock);
        #1;

        // ---- Directed table ------------------------------------------------
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].iv, vecs[i].ird,
                  vecs[i].rs1, vecs[i].rs2);
            #1;
            check($sformatf("vec%0d rs1_data", i), 64'(rs1_read_data), 64'(vecs[i].e_d1));
            check($sformatf("vec%0d rs1_busy", i), 64'(rs1_busy), 64'(vecs[i].e_b1));
            check($sformatf("vec%0d rs2_data", i), 64'(rs2_read_data), 64'(vecs[i].e_d2));
            check($sformatf("vec%0d rs2_busy", i), 64'(rs2_busy), 64'(vecs[i].e_b2));
            check($sformatf("vec%0d issue_ready", i), 64'(issue_ready), 64'(vecs[i].e_rdy));
            check($sformatf("vec%0d pending", i), 64'(pending_count), 64'(vecs[i].e_pend));
            tick();
        end

        // ---- Same-cycle write and read of x10 (busy, holds 0xA0) -----------
        drive(1'b1, 5'd10, 32'hCAFEF00D, 1'b0, 5'd0, 5'd10, 5'd9);
        #1;
        check("fwd rs1_data", 64'(rs1_read_data), Bypass ? 64'hCAFEF00D : 64'hA0);
        check("fwd rs1_busy", 64'(rs1_busy), Bypass ? 64'h0 : 64'h1);
        check_model("fwd");
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd9);
        #1;
        check("after_fwd rs1_data", 64'(rs1_read_data), 64'hCAFEF00D);
        check("after_fwd rs1_busy", 64'(rs1_busy), 64'h0);
        check("after_fwd pending", 64'(pending_count), 64'd3);

        // ---- Mid-cycle reset with 3 pending (x7, x8, x9) -------------------
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd5, 5'd7);
        #1;
        check("pre_rst rs1_data", 64'(rs1_read_data), 64'h55);
        check("pre_rst rs2_busy", 64'(rs2_busy), 64'h1);
        check("pre_rst issue_ready", 64'(issue_ready), 64'h0);
        reset = 1'b1;
        #1;
        check("mid_rst rs1_data", 64'(rs1_read_data), 64'h0);
        check("mid_rst rs2_busy", 64'(rs2_busy), 64'h0);
        check("mid_rst issue_ready", 64'(issue_ready), 64'h1);
        check("mid_rst pending", 64'(pending_count), 64'h0);
        drive(1'b1, 5'd5, 32'h77, 1'b1, 5'd12, 5'd5, 5'd12);
        #1;
        check("mid_rst_wr rs1_data", 64'(rs1_read_data), 64'h0);
        @(posedge clock);
        #1;
        check("mid_rst_edge rs1_data", 64'(rs1_read_data), 64'h0);
        check("mid_rst_edge rs2_busy", 64'(rs2_busy), 64'h0);
        check("mid_rst_edge pending", 64'(pending_count), 64'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        reset = 1'b0;
        m_reset();
        for (int a = 0; a < NREGS; a++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, AW'(a), AW'(NREGS - 1 - a));
            #1;
            check_model($sformatf("rst_clear a%0d", a));
        end
        @(posedge clock);
        #1;
        // First edge after release behaves normally.
        drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd2, 5'd1, 5'd2);
        #1;
        check_model("first_after_rst");
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd2, 5'd0);
        #1;
        check_model("first_after_rst2");
        tick();

        // ---- Randomized run against the model ------------------------------
        for (int c = 0; c < 1500; c++) begin
            logic [AW-1:0] rd_r;
            rd_r = AW'($urandom_range(0, 11));
            drive(1'($urandom_range(0, 1)), rd_r, $urandom(),
                  1'($urandom_range(0, 9) < 6), AW'($urandom_range(0, 11)),
                  ($urandom_range(0, 3) == 0) ? rd_r : AW'($urandom_range(0, NREGS - 1)),
                  ($urandom_range(0, 3) == 0) ? rd_r : AW'($urandom_range(0, 15)));
            #1;
            check_model($sformatf("rand%0d", c));
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                #1;
                check($sformatf("rand%0d rst pending", c), 64'(pending_count), 64'h0);
                reset = 1'b0;
                m_reset();
                #1;
                check_model($sformatf("rand%0d post_rst", c));
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of each register in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers (power of two, >= 2).
REQ-003 Parameter MAX_PENDING, default 4, maximum number of outstanding issued-but-unwritten destinations (1..NREGS-1).
REQ-004 Derived AW = clog2(NREGS); derived PW = clog2(MAX_PENDING+1).
REQ-005 Port list: one clock; reset is asynchronous and active-high.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- rs1_address  in  AW  read port 1 index
- rs1_read_data  out  XLEN  read port 1 data
- rs1_busy  out  1  read port 1 register awaiting writeback
- rs2_address  in  AW  read port 2 index
- rs2_read_data  out  XLEN  read port 2 data
- rs2_busy  out  1  read port 2 register awaiting writeback
- rd_address  in  AW  write port index
- rd_write_enable  in  1  write strobe
- rd_write_data  in  XLEN  write data
- issue_valid  in  1  request to reserve a destination
- issue_rd  in  AW  destination to reserve
- issue_ready  out  1  reservation accepted this cycle if issue_valid
- pending_count  out  PW  outstanding reservations

Function
REQ-006 Register 0 SHALL read as zero, ignore writes, never be busy, and never be counted as pending.
REQ-007 Reads SHALL be combinational (zero latency); writes SHALL take effect at the rising clock edge.
REQ-008 issue_ready SHALL be 1 when issue_rd is 0, else 1 iff busy[issue_rd]=0 and pending_count < MAX_PENDING; it SHALL NOT depend on issue_valid.
REQ-009 Accepted issue (issue_valid & issue_ready, issue_rd != 0) SHALL set busy[issue_rd] and increment pending_count at the next edge.
REQ-010 Write (rd_write_enable, rd_address != 0) to a busy register SHALL clear its busy bit and decrement pending_count at the next edge.
REQ-011 Write to a non-busy register SHALL update data only; busy bits and pending_count unchanged.
REQ-012 Simultaneous accepted issue and busy-clearing write SHALL leave pending_count unchanged; each bit updates independently.
REQ-013 Simultaneous accepted issue and write to the same non-busy register: data written, busy set, pending_count +1.
REQ-014 pending_count SHALL never exceed MAX_PENDING nor underflow below 0.
REQ-015 rsN_busy SHALL reflect the current busy bit of rsN_address (0 for address 0), subject to REQ-020.

Reset
REQ-016 Asserting reset SHALL immediately (without clock) clear all registers to 0, all busy bits to 0 and pending_count to 0.
REQ-017 During reset, rsN_read_data=0, rsN_busy=0, issue_ready=1; writes and issues are ignored.
REQ-018 Reset asserted mid-operation SHALL discard all outstanding reservations; first edge after deassertion operates normally.

Configuration
REQ-019 Macro REGFILE_SB_BYPASS_EN selects same-cycle write-to-read forwarding.
REQ-020 Defined: when rd_write_enable=1, rd_address != 0 and rsN_address = rd_address, rsN_read_data SHALL equal rd_write_data and rsN_busy SHALL be 0 in that cycle.
REQ-021 Not defined: reads SHALL return the pre-edge stored value and pre-edge busy bit; written data visible from the following cycle.

Verification
REQ-022 Reset, then read all addresses on both ports -> data 0, busy 0, pending_count 0, issue_ready 1.
REQ-023 Write 0xDEADBEEF to x0 and 0x12345678 to x5; read rs1=0, rs2=5 next cycle -> 0x00000000, 0x12345678.
REQ-024 Issue x3, x4, x6, x7 (MAX_PENDING=4) -> pending_count 4, issue_ready 0 for x8, 1 for x0; write x4 -> pending_count 3, rs busy for x4 = 0, x8 issue then accepted.
REQ-025 With x3 busy, same cycle issue x9 and write x3 -> pending_count unchanged, busy[3]=0, busy[9]=1; re-issue x9 -> issue_ready 0.
REQ-026 Write 0xCAFEF00D to x10 with rs1_address=10 same cycle -> with REGFILE_SB_BYPASS_EN rs1_read_data=0xCAFEF00D immediately; without, old value until next cycle.
REQ-027 Assert reset mid-cycle with 3 pending and nonzero data -> outputs clear before next edge; after release pending_count 0 and all reads 0.
